// File: rtl/chunked_cla_subtractor.sv
// Multi-cycle two's-complement subtractor resolving CHUNK bits per cycle with in-chunk carry lookahead.
// Optional build macro ADD_MODE_EN adds a sub_n port that selects a + b instead of a - b.
module chunked_cla_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADD_MODE_EN
    input  logic             sub_n,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int N = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_cfg
            $error("chunked_cla_subtractor: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    // Returns {carry_out, sum}; every carry is a flat sum of generate/propagate products.
    function automatic logic [CHUNK:0] cla_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK:0]   c;
        logic             term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            term = cin;
            for (int k = 0; k <= i; k++) term = term & p[k];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[CHUNK], p ^ c[CHUNK-1:0]};
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;
    logic             add_q;
    logic             op_add_in;
    logic             accept;
    logic             last_chunk;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   cla_res;

`ifdef ADD_MODE_EN
    assign op_add_in = sub_n;
`else
    assign op_add_in = 1'b0;
`endif

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign accept     = in_ready && in_valid;
    assign last_chunk = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_chunk = a_q[idx_q * CHUNK +: CHUNK];
        b_chunk = b_q[idx_q * CHUNK +: CHUNK];
        cla_res = cla_chunk(a_chunk, b_chunk, carry_q);
    end

    // b_q holds the effective second operand (~b for subtract), so the sign test
    // for overflow is "effective operands agree in sign and the result does not".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b1;
            idx_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            add_q    <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= op_add_in ? b : ~b;
            carry_q <= ~op_add_in;
            idx_q   <= '0;
            add_q   <= op_add_in;
        end else if (state_q == RUN) begin
            diff_q[idx_q * CHUNK +: CHUNK] <= cla_res[CHUNK-1:0];
            carry_q <= cla_res[CHUNK];
            if (last_chunk) begin
                idx_q    <= '0;
                borrow_q <= add_q ? cla_res[CHUNK] : ~cla_res[CHUNK];
                ovf_q    <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                            (cla_res[CHUNK-1] != a_q[WIDTH-1]);
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

endmodule
